// File: rtl/axis_merger.sv
// ---------------------------------------------------------------------------
// axis_merger
//
// Merges two free-running AXI-Stream sources into one registered AXI-Stream
// output. Each input owns a small FIFO. A round-robin arbiter drains both
// FIFOs into a single output register that honours M_AXIS_tready. Sources
// may ignore tready, so a word that arrives while its FIFO is full is
// dropped (and optionally counted).
//
// Optional feature macro: AXIS_MERGER_DROP_CNT_EN
//   defined     -> 16-bit saturating drop counters per input
//   not defined -> drop_count1/drop_count2 tied to 0
//
// Parameters
//   SAXIS_TDATA_WIDTH : input tdata width (both slave ports), signed data
//   MAXIS_TDATA_WIDTH : output tdata width (sign-extend or keep LSBs)
//   FIFO_DEPTH_LOG2   : log2 of per-input FIFO depth
//
// Ports
//   a_clk, a_rst                      : clock, synchronous active-high reset
//   S_AXIS1_* / S_AXIS2_*             : slave inputs (tdata, tvalid, tready)
//   M_AXIS_tdata/tvalid/tready/tuser  : merged master output, tuser = source
//                                       (0 = input 1, 1 = input 2)
//   monitor                           : last word accepted downstream
//   drop_count1, drop_count2          : per-input dropped-word counters
// ---------------------------------------------------------------------------
module axis_merger #(
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter int MAXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH_LOG2   = 2
) (
  input  logic                                a_clk,
  input  logic                                a_rst,
  input  logic signed [SAXIS_TDATA_WIDTH-1:0] S_AXIS1_tdata,
  input  logic                                S_AXIS1_tvalid,
  output logic                                S_AXIS1_tready,
  input  logic signed [SAXIS_TDATA_WIDTH-1:0] S_AXIS2_tdata,
  input  logic                                S_AXIS2_tvalid,
  output logic                                S_AXIS2_tready,
  output logic [MAXIS_TDATA_WIDTH-1:0]        M_AXIS_tdata,
  output logic                                M_AXIS_tvalid,
  input  logic                                M_AXIS_tready,
  output logic                                M_AXIS_tuser,
  output logic [MAXIS_TDATA_WIDTH-1:0]        monitor,
  output logic [15:0]                         drop_count1,
  output logic [15:0]                         drop_count2
);

  localparam int SW    = SAXIS_TDATA_WIDTH;
  localparam int MW    = MAXIS_TDATA_WIDTH;
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;

  localparam logic [0:0] LG_IN1 = 1'b0;
  localparam logic [0:0] LG_IN2 = 1'b1;

  // Signed size cast: sign-extends when widening, keeps LSBs when narrowing.
  function automatic logic signed [MW-1:0] conv_width(input logic signed [SW-1:0] d);
    return MW'(d);
  endfunction

`ifdef AXIS_MERGER_DROP_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction
`endif

  logic signed [SW-1:0] s_data [2];
  logic [1:0]           s_vld;
  logic [1:0]           full;
  logic [1:0]           empty;
  logic [1:0]           wr;
  logic [1:0]           pop;
  logic signed [SW-1:0] head [2];
  logic [1:0][15:0]     drop_cnt;

  assign s_data[0]      = S_AXIS1_tdata;
  assign s_data[1]      = S_AXIS2_tdata;
  assign s_vld          = {S_AXIS2_tvalid, S_AXIS1_tvalid};
  assign S_AXIS1_tready = ~full[0];
  assign S_AXIS2_tready = ~full[1];

  // ---- stage p0: per-input FIFOs ----
  for (genvar gi = 0; gi < 2; gi++) begin : g_in
    logic signed [SW-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          occ;

    // full comes from the occupancy register alone, so a same-cycle pop
    // never lets a write through.
    assign full[gi]  = (occ == (AW+1)'(DEPTH));
    assign empty[gi] = (occ == '0);
    assign wr[gi]    = s_vld[gi] & ~full[gi];
    assign head[gi]  = mem[rd_ptr];

    always_ff @(posedge a_clk) begin
      if (a_rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (wr[gi])  wr_ptr <= wr_ptr + AW'(1);
        if (pop[gi]) rd_ptr <= rd_ptr + AW'(1);
        case ({wr[gi], pop[gi]})
          2'b10:   occ <= occ + (AW+1)'(1);
          2'b01:   occ <= occ - (AW+1)'(1);
          default: occ <= occ;
        endcase
      end
    end

    always_ff @(posedge a_clk) begin
      if (wr[gi]) mem[wr_ptr] <= s_data[gi];
    end

`ifdef AXIS_MERGER_DROP_CNT_EN
    logic [15:0] cnt;
    always_ff @(posedge a_clk) begin
      if (a_rst)                        cnt <= '0;
      else if (s_vld[gi] & full[gi])    cnt <= sat_inc(cnt);
    end
    assign drop_cnt[gi] = cnt;
`else
    assign drop_cnt[gi] = '0;
`endif
  end

  assign drop_count1 = drop_cnt[0];
  assign drop_count2 = drop_cnt[1];

  // ---- stage p1: arbiter and output register ----
  logic                 vld_p1;
  logic signed [MW-1:0] data_p1;
  logic                 user_p1;
  logic [0:0]           last_grant;
  logic [MW-1:0]        monitor_p1;
  logic                 xfer;
  logic                 load;
  logic                 grant2;

  assign xfer   = vld_p1 & M_AXIS_tready;
  assign load   = (~vld_p1 | M_AXIS_tready) & ~(&empty);
  // Input 2 wins when it is the only requester, or when both request and
  // input 1 was served last.
  assign grant2 = ~empty[1] & (empty[0] | (last_grant == LG_IN1));
  assign pop    = {load & grant2, load & ~grant2};

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      user_p1    <= 1'b0;
      last_grant <= LG_IN2;
      monitor_p1 <= '0;
    end else begin
      if (xfer) monitor_p1 <= data_p1;
      if (load) begin
        vld_p1     <= 1'b1;
        data_p1    <= conv_width(grant2 ? head[1] : head[0]);
        user_p1    <= grant2;
        last_grant <= grant2 ? LG_IN2 : LG_IN1;
      end else if (xfer) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign M_AXIS_tvalid = vld_p1;
  assign M_AXIS_tdata  = data_p1;
  assign M_AXIS_tuser  = user_p1;
  assign monitor       = monitor_p1;

endmodule

// File: tb/tb_axis_merger.sv
// ---------------------------------------------------------------------------
// tb_axis_merger
//
// Randomized and directed stimulus against axis_merger (16-bit inputs,
// 32-bit output, depth-4 FIFOs). A queue-based reference model predicts each
// output word; a separate negedge monitor compares DUT transfers against the
// expected-word queue and checks tready, tvalid, monitor and drop counters.
// ---------------------------------------------------------------------------
module tb_axis_merger;

  localparam int SW    = 16;
  localparam int MW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic [SW-1:0] d1, d2;
  logic          v1, v2;
  logic          r1, r2;
  logic [MW-1:0] mdata;
  logic          mvalid;
  logic          mready;
  logic          muser;
  logic [MW-1:0] mon;
  logic [15:0]   dc1, dc2;

  axis_merger #(
    .SAXIS_TDATA_WIDTH(SW),
    .MAXIS_TDATA_WIDTH(MW),
    .FIFO_DEPTH_LOG2  (AW)
  ) dut (
    .a_clk         (clk),
    .a_rst         (rst),
    .S_AXIS1_tdata (d1),
    .S_AXIS1_tvalid(v1),
    .S_AXIS1_tready(r1),
    .S_AXIS2_tdata (d2),
    .S_AXIS2_tvalid(v2),
    .S_AXIS2_tready(r2),
    .M_AXIS_tdata  (mdata),
    .M_AXIS_tvalid (mvalid),
    .M_AXIS_tready (mready),
    .M_AXIS_tuser  (muser),
    .monitor       (mon),
    .drop_count1   (dc1),
    .drop_count2   (dc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [MW-1:0] data;
    bit            user;
  } item_t;

  logic [SW-1:0] q1[$];
  logic [SW-1:0] q2[$];
  item_t         expq[$];
  bit            m_vld;
  logic [MW-1:0] m_data;
  int            m_last;
  logic [MW-1:0] mon_exp;
  int            drops1, drops2;
  bit            started;
  bit            rst_last;

  // Two's-complement reinterpretation of the 16-bit word as a 32-bit value.
  function automatic logic [MW-1:0] ext(input logic [SW-1:0] d);
    int v;
    v = int'(d);
    if (v >= (1 << (SW-1))) v = v - (1 << SW);
    return MW'(v);
  endfunction

  task automatic model_step();
    bit    consumed, full1, full2;
    int    pick;
    item_t it;
    rst_last = rst;
    if (rst) begin
      q1.delete(); q2.delete(); expq.delete();
      m_vld = 0; m_data = '0; m_last = 2; mon_exp = '0;
      drops1 = 0; drops2 = 0;
      started = 1;
      return;
    end
    consumed = m_vld && mready;
    if (consumed) mon_exp = m_data;
    full1 = (q1.size() == DEPTH);
    full2 = (q2.size() == DEPTH);
    if ((!m_vld || consumed) && (q1.size() > 0 || q2.size() > 0)) begin
      if (q1.size() > 0 && q2.size() > 0) pick = (m_last == 1) ? 2 : 1;
      else                                pick = (q1.size() > 0) ? 1 : 2;
      if (pick == 1) it.data = ext(q1.pop_front());
      else           it.data = ext(q2.pop_front());
      it.user = (pick == 2);
      m_vld   = 1;
      m_data  = it.data;
      m_last  = pick;
      expq.push_back(it);
    end else if (consumed) begin
      m_vld = 0;
    end
    if (v1) begin
      if (full1) drops1++;
      else       q1.push_back(d1);
    end
    if (v2) begin
      if (full2) drops2++;
      else       q2.push_back(d2);
    end
  endtask

  function automatic logic [15:0] exp_drop(input int n);
`ifdef AXIS_MERGER_DROP_CNT_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return (n < 0) ? 16'hFFFF : 16'h0000;
`endif
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (started) begin
      item_t e;
      chk("tvalid", mvalid, m_vld);
      chk("s1_tready", r1, q1.size() < DEPTH);
      chk("s2_tready", r2, q2.size() < DEPTH);
      chk("monitor", mon, mon_exp);
      chk("drop_count1", dc1, exp_drop(drops1));
      chk("drop_count2", dc2, exp_drop(drops2));
      if (rst_last) begin
        chk("reset_tdata", mdata, 0);
        chk("reset_tuser", muser, 0);
      end
      if (mvalid === 1'b1 && mready === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", mdata);
        end else begin
          e = expq.pop_front();
          chk("xfer_tdata", mdata, e.data);
          chk("xfer_tuser", muser, e.user);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit a1, input logic [SW-1:0] x1,
                     input bit a2, input logic [SW-1:0] x2,
                     input bit rdy, input bit r);
    rst = r; v1 = a1; d1 = x1; v2 = a2; d2 = x2; mready = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  int unsigned p1, p2, pr;
  logic [15:0] dc1_before;

  initial begin
    rst = 1'b1; v1 = 0; v2 = 0; d1 = '0; d2 = '0; mready = 1'b1;
    started = 0; rst_last = 0;
    m_vld = 0; m_data = '0; m_last = 2; mon_exp = '0; drops1 = 0; drops2 = 0;

    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);

    // single word, latency and monitor
    cyc(1, 16'h0011, 0, 0, 1, 0);
    chk("t1_tvalid_early", mvalid, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t1_tvalid", mvalid, 1);
    chk("t1_tdata", mdata, 32'h11);
    chk("t1_tuser", muser, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t1_monitor", mon, 32'h11);
    cyc(0, 0, 0, 0, 1, 0);

    // both inputs streaming: round-robin from input 1
    for (int i = 0; i < 8; i++)
      cyc(1, 16'h00A0 + 16'(i), 1, 16'h00B0 + 16'(i), 1, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 1, 0);

    // back-pressure: 6 words into input 1 with tready low
    dc1_before = dc1;
    for (int i = 0; i < 6; i++) cyc(1, 16'h00C0 + 16'(i), 0, 0, 0, 0);
    chk("t3_s1_tready", r1, 0);
`ifdef AXIS_MERGER_DROP_CNT_EN
    chk("t3_drop_delta", dc1 - dc1_before, 1);
`else
    chk("t3_drop_tied", dc1, 0);
`endif
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 0);

    // sign extension
    cyc(1, 16'h8001, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("sext_monitor", mon, 32'hFFFF8001);

    // reset with words buffered
    cyc(1, 16'h1111, 1, 16'h2222, 0, 0);
    cyc(1, 16'h1112, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_tvalid", mvalid, 0);
    chk("rst_s1_tready", r1, 1);
    chk("rst_s2_tready", r2, 1);
    chk("rst_dc1", dc1, 0);
    chk("rst_dc2", dc2, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, 0);

    // randomized traffic with shifting rates and occasional reset
    p1 = 50; p2 = 50; pr = 70;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        p1 = $urandom_range(0, 100);
        p2 = $urandom_range(0, 100);
        pr = $urandom_range(0, 100);
      end
      cyc($urandom_range(0, 99) < p1, 16'($urandom),
          $urandom_range(0, 99) < p2, 16'($urandom),
          $urandom_range(0, 99) < pr, $urandom_range(0, 699) == 0);
    end

    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("final_expq_empty", expq.size(), 0);
    chk("final_tvalid", mvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
